// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch sequencer.
// The optional performance counters in fetch_unit are enabled by FETCH_PERF_CNT_EN.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   localparam int FETCH_PC_W   = 10;
   localparam int FETCH_LUT_AW = 5;

endpackage

// File: rtl/fetch_tgt_lut.sv
// Branch/jump target table: one synchronous write port, one asynchronous read port.
// A same-index write and read in one cycle returns the old entry.
module fetch_tgt_lut #(
   parameter int AW = 5,
   parameter int DW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Program-counter / instruction-fetch sequencer with IDLE/RUN/HALT handshake.
// Define FETCH_PERF_CNT_EN to add the CycCnt / TakenCnt performance counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int PC_W   = FETCH_PC_W,
   parameter int LUT_AW = FETCH_LUT_AW
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic [PC_W-1:0]   StartAddr,
   input  logic              Halt,
   input  logic              Jump,
   input  logic              BranchEn,
   input  logic              Zero,
   input  logic [LUT_AW-1:0] TgtIdx,
   input  logic              TgtWe,
   input  logic [LUT_AW-1:0] TgtAddr,
   input  logic [PC_W-1:0]   TgtData,
   output logic [PC_W-1:0]   ProgCtr,
   output logic              Busy,
   output logic              Done
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]       CycCnt,
   output logic [15:0]       TakenCnt
`endif
);

   fetch_state_t    state_q;
   fetch_state_t    state_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic [PC_W-1:0] tgt;
   logic            redirect;
   logic            busy_nxt;
   logic            done_nxt;

   fetch_tgt_lut #(
      .AW (LUT_AW),
      .DW (PC_W)
   ) u_lut (
      .clk   (Clk),
      .rst_n (Reset_n),
      .we    (TgtWe),
      .waddr (TgtAddr),
      .wdata (TgtData),
      .raddr (TgtIdx),
      .rdata (tgt)
   );

   // Jump outranks branch; both share the table lookup.
   assign redirect = Jump || (BranchEn && Zero);

   always_comb begin
      state_nxt = state_q;
      pc_nxt    = ProgCtr;
      case (state_q)
         IDLE, HALT: begin
            if (Start) begin
               pc_nxt    = StartAddr;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (Halt) begin
               state_nxt = HALT;
            end else if (redirect) begin
               pc_nxt = tgt;
            end else begin
               pc_nxt = ProgCtr + PC_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt == RUN);
      done_nxt = (state_nxt == HALT);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         ProgCtr <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         ProgCtr <= pc_nxt;
         Busy    <= busy_nxt;
         Done    <= done_nxt;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic start_acc;
   logic taken;

   assign start_acc = Start && (state_q != RUN);
   assign taken     = (state_q == RUN) && !Halt && redirect;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         CycCnt   <= '0;
         TakenCnt <= '0;
      end else if (start_acc) begin
         CycCnt   <= '0;
         TakenCnt <= '0;
      end else begin
         if ((state_q == RUN) && (CycCnt != 16'hFFFF)) begin
            CycCnt <= CycCnt + 16'd1;
         end
         if (taken && (TakenCnt != 16'hFFFF)) begin
            TakenCnt <= TakenCnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a reference model.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;

   localparam int PC_W   = 10;
   localparam int LUT_AW = 5;
   localparam int PC_MOD = 1 << PC_W;

   logic              Clk;
   logic              Reset_n;
   logic              Start;
   logic [PC_W-1:0]   StartAddr;
   logic              Halt;
   logic              Jump;
   logic              BranchEn;
   logic              Zero;
   logic [LUT_AW-1:0] TgtIdx;
   logic              TgtWe;
   logic [LUT_AW-1:0] TgtAddr;
   logic [PC_W-1:0]   TgtData;
   logic [PC_W-1:0]   ProgCtr;
   logic              Busy;
   logic              Done;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0]       CycCnt;
   logic [15:0]       TakenCnt;
`endif

   fetch_unit #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Start     (Start),
      .StartAddr (StartAddr),
      .Halt      (Halt),
      .Jump      (Jump),
      .BranchEn  (BranchEn),
      .Zero      (Zero),
      .TgtIdx    (TgtIdx),
      .TgtWe     (TgtWe),
      .TgtAddr   (TgtAddr),
      .TgtData   (TgtData),
      .ProgCtr   (ProgCtr),
      .Busy      (Busy),
      .Done      (Done)
`ifdef FETCH_PERF_CNT_EN
      ,
      .CycCnt    (CycCnt),
      .TakenCnt  (TakenCnt)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // reference model: mode 0 = idle, 1 = running, 2 = halted
   int m_mode;
   int m_pc;
   int m_lut [1 << LUT_AW];
   int m_cyc;
   int m_taken;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_pc    = 0;
      m_cyc   = 0;
      m_taken = 0;
      for (int i = 0; i < (1 << LUT_AW); i++) m_lut[i] = 0;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_pc"},   32'(ProgCtr), 32'(m_pc));
      check({tag, "_busy"}, 32'(Busy),    32'(m_mode == 1));
      check({tag, "_done"}, 32'(Done),    32'(m_mode == 2));
`ifdef FETCH_PERF_CNT_EN
      check({tag, "_cyc"},   32'(CycCnt),   32'(m_cyc));
      check({tag, "_taken"}, 32'(TakenCnt), 32'(m_taken));
`endif
   endtask

   // Drive one cycle of inputs, advance the model, clock the DUT and compare.
   task automatic step(input string tag, input logic st, input int sa,
                       input logic h, input logic j, input logic b, input logic z,
                       input int ti, input logic we, input int wa, input int wd);
      int n_mode, n_pc, n_cyc, n_taken;
      Start     = st;
      StartAddr = PC_W'(sa);
      Halt      = h;
      Jump      = j;
      BranchEn  = b;
      Zero      = z;
      TgtIdx    = LUT_AW'(ti);
      TgtWe     = we;
      TgtAddr   = LUT_AW'(wa);
      TgtData   = PC_W'(wd);
      n_mode  = m_mode;
      n_pc    = m_pc;
      n_cyc   = m_cyc;
      n_taken = m_taken;
      if (m_mode == 1) begin
         n_cyc = (m_cyc < 65535) ? m_cyc + 1 : 65535;
         if (h) begin
            n_mode = 2;
         end else if (j || (b && z)) begin
            n_pc    = m_lut[ti];
            n_taken = (m_taken < 65535) ? m_taken + 1 : 65535;
         end else begin
            n_pc = (m_pc + 1) % PC_MOD;
         end
      end else if (st) begin
         n_mode  = 1;
         n_pc    = sa % PC_MOD;
         n_cyc   = 0;
         n_taken = 0;
      end
      @(posedge Clk);
      #1;
      m_mode  = n_mode;
      m_pc    = n_pc;
      m_cyc   = n_cyc;
      m_taken = n_taken;
      if (we) m_lut[wa] = wd % PC_MOD;
      check_model(tag);
   endtask

   task automatic idle_step(input string tag);
      step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      Reset_n = 1'b0;
      Start = 0; StartAddr = '0; Halt = 0; Jump = 0; BranchEn = 0; Zero = 0;
      TgtIdx = '0; TgtWe = 0; TgtAddr = '0; TgtData = '0;
      model_reset();
      #12;
      check("rst_pc",   32'(ProgCtr), 32'd0);
      check("rst_busy", 32'(Busy),    32'd0);
      check("rst_done", 32'(Done),    32'd0);
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;

      // idle ignores control inputs
      step("idle_ctl", 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);

      // start at 5 and count up
      step("start5", 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      idle_step("inc1");
      idle_step("inc2");
      idle_step("inc3");
      check("seq_pc8", 32'(ProgCtr), 32'd8);

      // start during run is ignored
      step("start_in_run", 1, 77, 0, 0, 0, 0, 0, 0, 0, 0);

      // jump and branch through LUT[3]=200
      step("wr_lut3", 0, 0, 0, 0, 0, 0, 0, 1, 3, 200);
      step("jump3", 0, 0, 0, 1, 0, 0, 3, 0, 0, 0);
      check("jump_pc200", 32'(ProgCtr), 32'd200);
      step("br_nz", 0, 0, 0, 0, 1, 0, 3, 0, 0, 0);
      check("br_untaken", 32'(ProgCtr), 32'd201);
      step("br_z", 0, 0, 0, 0, 1, 1, 3, 0, 0, 0);
      check("br_taken", 32'(ProgCtr), 32'd200);
      step("jump_and_br", 0, 0, 0, 1, 1, 0, 3, 0, 0, 0);

      // halt beats jump at ProgCtr=12
      step("wr_lut1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 12);
      step("jump1", 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      step("halt_jump", 0, 0, 1, 1, 0, 0, 3, 0, 0, 0);
      check("halt_pc12", 32'(ProgCtr), 32'd12);
      check("halt_done", 32'(Done),    32'd1);
      check("halt_busy", 32'(Busy),    32'd0);
      step("halted_ctl", 0, 0, 0, 1, 1, 1, 3, 0, 0, 0);
      step("restart0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("restart_pc", 32'(ProgCtr), 32'd0);
      check("restart_done", 32'(Done),  32'd0);

      // wrap at 1023 and write/read collision on LUT[3]
      step("wr_lut2", 0, 0, 0, 0, 0, 0, 0, 1, 2, 1023);
      step("jump2", 0, 0, 0, 1, 0, 0, 2, 0, 0, 0);
      idle_step("wrap");
      check("wrap_pc0", 32'(ProgCtr), 32'd0);
      step("wr_rd_same", 0, 0, 0, 1, 0, 0, 3, 1, 3, 9);
      check("old_lut_val", 32'(ProgCtr), 32'd200);
      step("new_lut_val", 0, 0, 0, 1, 0, 0, 3, 0, 0, 0);
      check("new_lut_pc9", 32'(ProgCtr), 32'd9);

`ifdef FETCH_PERF_CNT_EN
      // 10 RUN cycles with 2 taken and 1 untaken branch
      step("cnt_start", 1, 100, 0, 0, 0, 0, 0, 0, 0, 0);
      step("cnt_halt_pre", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step("cnt_start2", 1, 100, 0, 0, 0, 0, 0, 0, 0, 0);
      check("cnt_clr_cyc", 32'(CycCnt), 32'd0);
      step("cnt_b1", 0, 0, 0, 0, 1, 1, 3, 0, 0, 0);
      step("cnt_b2", 0, 0, 0, 0, 1, 0, 3, 0, 0, 0);
      step("cnt_b3", 0, 0, 0, 0, 1, 1, 3, 0, 0, 0);
      for (int i = 0; i < 7; i++) idle_step("cnt_run");
      check("cnt_cyc10",  32'(CycCnt),   32'd10);
      check("cnt_taken2", 32'(TakenCnt), 32'd2);
      step("cnt_halt", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle_step("cnt_hold");
      step("cnt_restart", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("cnt_clr_cyc2",   32'(CycCnt),   32'd0);
      check("cnt_clr_taken2", 32'(TakenCnt), 32'd0);
`endif

      // asynchronous reset mid-run at ProgCtr=37
      step("wr_lut4", 0, 0, 0, 0, 0, 0, 0, 1, 4, 37);
      step("jump4", 0, 0, 0, 1, 0, 0, 4, 0, 0, 0);
      check("pre_rst_pc37", 32'(ProgCtr), 32'd37);
      #2;
      Reset_n = 1'b0;
      #1;
      check("async_rst_pc",   32'(ProgCtr), 32'd0);
      check("async_rst_busy", 32'(Busy),    32'd0);
      check("async_rst_done", 32'(Done),    32'd0);
      model_reset();
      #1;
      Reset_n = 1'b1;
      step("post_rst_start", 1, 50, 0, 0, 0, 0, 0, 0, 0, 0);
      step("lut_cleared", 0, 0, 0, 1, 0, 0, 4, 0, 0, 0);
      check("lut4_zero", 32'(ProgCtr), 32'd0);

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         step("rnd",
              ($urandom_range(0, 7) == 0), int'($urandom_range(0, PC_MOD - 1)),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
              int'($urandom_range(0, (1 << LUT_AW) - 1)),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, (1 << LUT_AW) - 1)),
              int'($urandom_range(0, PC_MOD - 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
